// File: rtl/stream_mux_pkg.sv
// Shared definitions for the N-to-1 stream multiplexer and its round-robin arbiter.
package stream_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/stream_mux_n_to_one_rr_arbiter.sv
// Rotating-priority arbiter: the search starts just after the last granted
// channel and wraps modulo N. The result is one-hot, or zero when disabled or idle.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last,
  input  logic          en,
  output logic [N-1:0]  gnt
);

  logic [SW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    if (en) begin
      for (int k = 1; k <= N; k++) begin
        idx = SW'((int'(last) + k) % N);
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_n_to_one.sv
// Registered N-to-1 valid/ready stream mux with explicit-select and round-robin
// modes; a single output register gives one-cycle latency at full throughput.
module stream_mux_n_to_one
  import stream_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  input  logic           out_ready
);

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_chan_q,  out_chan_d;
  logic [SW-1:0] last_q,      last_d;

  logic [N-1:0]  sel_hit;
  logic [N-1:0]  grant_sel;
  logic [N-1:0]  grant_rr;
  logic [N-1:0]  grant;
  logic [W-1:0]  masked_data [N];
  logic [W-1:0]  mux_data;
  logic [SW-1:0] mux_chan;
  logic          load;
  logic          in_xfer;

  // A decoded select never matches a code >= N, so unused codes grant nothing.
  for (genvar gi = 0; gi < N; gi++) begin : g_sel
    assign sel_hit[gi] = (sel == SW'(gi));
  end
  assign grant_sel = in_valid & sel_hit;

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_rr_arbiter (
    .req  (in_valid),
    .last (last_q),
    .en   (mode == MODE_RR),
    .gnt  (grant_rr)
  );

  assign grant    = (mode == MODE_RR) ? grant_rr : grant_sel;
  assign load     = !out_valid_q || out_ready;
  assign in_ready = grant & {N{load}};
  assign in_xfer  = |in_ready;

  // AND-OR data mux: each lane is gated by its grant bit, then all lanes are ORed.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign masked_data[gi] = {W{grant[gi]}} & in_data[gi*W +: W];
  end

  always_comb begin
    mux_data = '0;
    mux_chan = '0;
    for (int i = 0; i < N; i++) begin
      mux_data = mux_data | masked_data[i];
      if (grant[i]) begin
        mux_chan = mux_chan | SW'(i);
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    last_d      = last_q;
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_chan_d  = mux_chan;
      if (mode == MODE_RR) begin
        last_d = mux_chan;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      last_q      <= SW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_n_to_one.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a behavioural model of the mux (N=4), and a N=5 instance for unused select codes.
module tb_stream_mux_n_to_one;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic [1:0]  sel = '0;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_ready = 1'b0;

  logic [2:0]  sel5 = '0;
  logic [4:0]  in_valid5 = '0;
  logic [39:0] in_data5 = '0;
  logic [4:0]  in_ready5;
  logic        out_valid5;
  logic [7:0]  out_data5;
  logic [2:0]  out_chan5;
  logic        out_ready5 = 1'b0;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  logic       m_valid;
  logic [7:0] m_data;
  int         m_chan;
  int         m_last;

  always #5 clk = ~clk;

  stream_mux_n_to_one #(.N(4), .W(8)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
    .out_ready(out_ready)
  );

  stream_mux_n_to_one #(.N(5), .W(8)) u_dut5 (
    .clk(clk), .rst(rst), .mode(1'b0), .sel(sel5),
    .in_valid(in_valid5), .in_data(in_data5), .in_ready(in_ready5),
    .out_valid(out_valid5), .out_data(out_data5), .out_chan(out_chan5),
    .out_ready(out_ready5)
  );

  // Expected in_ready from the current inputs and model state.
  function automatic logic [3:0] model_ready();
    logic [3:0] g;
    int i;
    g = '0;
    if (mode == 1'b0) begin
      if (in_valid[sel]) g[sel] = 1'b1;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        i = (m_last + k) % 4;
        if (in_valid[i]) begin
          g[i] = 1'b1;
          break;
        end
      end
    end
    if (m_valid && !out_ready) g = '0;
    return g;
  endfunction

  // Advance one clock and update the model; returns at posedge+1.
  task automatic tick();
    logic [3:0] r;
    logic [31:0] d;
    logic       md, ordy, rs;
    r = model_ready();
    d = in_data;
    md = mode;
    ordy = out_ready;
    rs = rst;
    @(posedge clk);
    if (rs) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_chan  = 0;
      m_last  = 3;
    end else if (r != 4'b0) begin
      for (int i = 0; i < 4; i++) begin
        if (r[i]) begin
          m_data  = d[i*8 +: 8];
          m_chan  = i;
          m_valid = 1'b1;
          if (md) m_last = i;
          $display("xfer in  ch=%0d data=%02h mode=%0d", i, d[i*8 +: 8], md);
        end
      end
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = '0;
    in_valid5 = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
      failures++;
      $display("FAIL reset_state valid=%0b data=%02h chan=%0d exp 0/00/0", out_valid, out_data, out_chan);
    end
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data = 32'h0000_005A; out_ready = 1'b0;
    tick();
    in_valid = '0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
      failures++;
      $display("FAIL reset_preload valid=%0b data=%02h exp 1/5a", out_valid, out_data);
    end
    rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
      failures++;
      $display("FAIL reset_midstream valid=%0b data=%02h chan=%0d exp 0/00/0", out_valid, out_data, out_chan);
    end
    mode = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_rr in_ready=%b exp 0001", in_ready);
    end
    tick();
  endtask

  task automatic test_sel();
    apply_reset();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; in_data = 32'h44_33_22_11; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++;
      $display("FAIL sel_ready in_ready=%b exp 0100", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h33 || out_chan !== 2'd2) begin
      failures++;
      $display("FAIL sel_data valid=%0b data=%02h chan=%0d exp 1/33/2", out_valid, out_data, out_chan);
    end
    in_valid = 4'b1011;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL sel_idle_ready in_ready=%b exp 0000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h33) begin
      failures++;
      $display("FAIL sel_idle_drain valid=%0b data=%02h exp 0/33", out_valid, out_data);
    end
  endtask

  task automatic test_sel_out_of_range();
    apply_reset();
    sel5 = 3'd4; in_valid5 = 5'b11111; in_data5 = 40'hC4_C3_C2_C1_C0; out_ready5 = 1'b1;
    tick();
    checks++;
    if (out_valid5 !== 1'b1 || out_chan5 !== 3'd4 || out_data5 !== 8'hC4) begin
      failures++;
      $display("FAIL sel5_ch4 valid=%0b chan=%0d data=%02h exp 1/4/c4", out_valid5, out_chan5, out_data5);
    end
    sel5 = 3'd6;
    #1;
    checks++;
    if (in_ready5 !== 5'b00000) begin
      failures++;
      $display("FAIL sel5_oor_ready in_ready=%b exp 00000", in_ready5);
    end
    tick();
    checks++;
    if (out_valid5 !== 1'b0) begin
      failures++;
      $display("FAIL sel5_oor_valid valid=%0b exp 0", out_valid5);
    end
    in_valid5 = '0;
  endtask

  task automatic test_rr_full();
    int e;
    apply_reset();
    mode = 1'b1; in_valid = 4'b1111; in_data = 32'h13_12_11_10; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      e = c % 4;
      #1;
      checks++;
      if (in_ready !== 4'(1 << e)) begin
        failures++;
        $display("FAIL rr_full_ready step=%0d in_ready=%b exp ch%0d", c, in_ready, e);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_chan !== 2'(e) || out_data !== 8'(8'h10 + e)) begin
        failures++;
        $display("FAIL rr_full_out step=%0d valid=%0b chan=%0d data=%02h exp 1/%0d/%02h",
                 c, out_valid, out_chan, out_data, e, 8'h10 + e);
      end
    end
  endtask

  task automatic test_rr_sparse();
    int exp_seq [3] = '{3, 1, 3};
    apply_reset();
    mode = 1'b1; in_valid = 4'b0010; in_data = 32'hD3_D2_D1_D0; out_ready = 1'b1;
    tick();
    in_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'(1 << exp_seq[c])) begin
        failures++;
        $display("FAIL rr_sparse_ready step=%0d in_ready=%b exp ch%0d", c, in_ready, exp_seq[c]);
      end
      tick();
      checks++;
      if (out_chan !== 2'(exp_seq[c])) begin
        failures++;
        $display("FAIL rr_sparse_chan step=%0d chan=%0d exp %0d", c, out_chan, exp_seq[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data = 32'h0000_00A1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_data = 32'h0000_00A2;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_ready cycle=%0d in_ready=%b exp 0000", c, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA1 || out_chan !== 2'd0) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d valid=%0b data=%02h exp 1/a1", c, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL bp_release_ready in_ready=%b exp 0001", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA2) begin
      failures++;
      $display("FAIL bp_replace valid=%0b data=%02h exp 1/a2", out_valid, out_data);
    end
  endtask

  task automatic test_mode_switch();
    apply_reset();
    mode = 1'b1; in_valid = 4'b0100; in_data = 32'hE3_E2_E1_E0; out_ready = 1'b1;
    tick();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001;
    tick();
    checks++;
    if (out_chan !== 2'd0 || out_data !== 8'hE0) begin
      failures++;
      $display("FAIL mode_sel_leg chan=%0d data=%02h exp 0/e0", out_chan, out_data);
    end
    mode = 1'b1; in_valid = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      failures++;
      $display("FAIL mode_rr_resume in_ready=%b exp 1000", in_ready);
    end
    tick();
    checks++;
    if (out_chan !== 2'd3 || out_data !== 8'hE3) begin
      failures++;
      $display("FAIL mode_rr_out chan=%0d data=%02h exp 3/e3", out_chan, out_data);
    end
  endtask

  task automatic test_random();
    logic [3:0] er;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      #1;
      er = model_ready();
      checks++;
      if (in_ready !== er) begin
        failures++;
        $display("FAIL rand_ready cycle=%0d in_ready=%b exp %b", c, in_ready, er);
      end
      tick();
      checks++;
      if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_chan !== 2'(m_chan)))) begin
        failures++;
        $display("FAIL rand_out cycle=%0d valid=%0b data=%02h chan=%0d exp %0b/%02h/%0d",
                 c, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
    m_last  = 3;
    test_reset();
    test_sel();
    test_sel_out_of_range();
    test_rr_full();
    test_rr_sparse();
    test_backpressure();
    test_mode_switch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
